whirlpool_sub_bytes_seq: RTL and testbench
==========================================

Name: whirlpool_sub_bytes_seq

Overview:
- Sequential SubBytes engine for the Whirlpool round datapath.
- Accepts a full 512-bit state over a valid/ready handshake and applies the Whirlpool S-box to LANES bytes per cycle, reusing the existing combinational S-box LANES times.
- Returns the substituted state over a second valid/ready handshake.
- Trades area for latency through LANES; optional pipeline register after the S-box lanes for timing closure.

Parameters:
- STATE_BYTES, 64, bytes in the state. Must be divisible by LANES; otherwise elaboration error.
- LANES, 8, S-box instances, i.e. bytes substituted per cycle. Range 1..STATE_BYTES.
- PIPE, 0, 0 = S-box result written back the same cycle; 1 = result registered first, adds 1 cycle latency.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input state valid
- in_ready  output  1  engine can accept a state
- in_state  input  8*STATE_BYTES  state; byte i = in_state[8*i+7:8*i]
- out_valid  output  1  substituted state valid
- out_ready  input  1  consumer accepts out_state
- out_state  output  8*STATE_BYTES  substituted state, same byte order
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - Beat counter cnt and state buffer clear to 0; pipe stage valid clears.
  - Outputs: in_ready=1 after deassertion; out_valid=0; out_state=0; busy=0.
  - Reset mid-RUN or mid-DONE discards the state; no output is produced for it.
- Derived constant: BEATS = STATE_BYTES/LANES. cnt width = max(1, clog2(BEATS)).
- FSM state IDLE:
  - in_ready=1.
  - On in_valid: capture in_state into buffer, cnt<=0, go to RUN.
- FSM state RUN:
  - in_ready=0.
  - Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the buffer feed the LANES S-boxes.
  - PIPE=0: the result overwrites the same slice at the clock edge; cnt increments. When cnt==BEATS-1, go to DONE (no cnt wrap).
  - PIPE=1: the result and its slice index load a stage register; the stage writes back on the next edge. Sequence of RUN cycles:
    - issue slices 0..BEATS-1 on RUN cycles 0..BEATS-1;
    - write back slice k at the end of RUN cycle k+1;
    - go to DONE after the final writeback, giving BEATS+1 RUN cycles total.
- FSM state DONE:
  - out_valid=1; out_state=buffer, held stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid drops next cycle.
  - in_ready stays 0 in DONE, so an input cannot be accepted in the same cycle as an output handoff. The earliest next accept is the cycle after handoff.
- Latency: in_valid&in_ready sampled at edge E gives out_valid=1 from edge E+BEATS+PIPE. Throughput: one state per BEATS+PIPE+2 cycles at best.
- BEATS=1 (LANES=STATE_BYTES): RUN lasts 1 cycle (PIPE=0) or 2 cycles (PIPE=1).
- Handshake rules:
  - in_valid is ignored outside IDLE; in_state is sampled only at the accept edge.
  - out_state and out_valid are stable until accepted.
- Only the buffer is visible on out_state, and only during DONE. Outside DONE out_state is undefined by contract; the implementation drives the buffer.
- Substitution is per byte and position-independent: out byte i = S(in byte i), with no mixing.

Decomposition:
- Shared whirlpool package holds:
  - default STATE_BYTES=64;
  - FSM state encoding localparam (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 helper function.
- The one natural sub-module is the existing combinational whirlpool_sbox, instantiated LANES times via generate. No other sub-modules.

Test Plan:
- Reset/idle: assert rst_n=0 mid-RUN (LANES=8, cycle 3). Required: out_valid=0, busy=0, in_ready=1 after release, and no output ever appears for the aborted state.
- Known bytes: in_state with byte0=0x00, byte1=0x01, byte2=0x06, byte63=0xFF, all others 0x00. Required: out byte0=0x18, byte1=0x23, byte2=0x01, byte63=0x86, all other bytes 0x18.
- Latency sweep: LANES in {1,8,64} x PIPE in {0,1}, accept at edge E. Required: out_valid first high at E+BEATS+PIPE (E+64, E+65, E+8, E+9, E+1, E+2).
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new state. Required: out_state stable, in_ready=0, second state not accepted until the cycle after out_ready=1.
- Full-table check: 4 states covering bytes 0x00..0xFF (byte i of state k = 64k+i). Required: every output byte matches the Whirlpool S-box table, e.g. 0x10 maps to 0x60 and 0x0F maps to 0x52.
- Back-to-back: in_valid and out_ready held high for 5 random states. Required: each result correct, in order, and the interval between out_valid rises is BEATS+PIPE+2 cycles.

Source files
------------

// File: rtl/whirlpool_sub_bytes_seq_pkg.sv
// rtl/whirlpool_sub_bytes_seq_pkg.sv - shared constants, FSM encoding and helpers for the Whirlpool SubBytes engine
package whirlpool_sub_bytes_seq_pkg;

    localparam int WP_STATE_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wp_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int wp_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/whirlpool_sub_bytes_seq_sbox.sv
// rtl/whirlpool_sub_bytes_seq_sbox.sv - combinational Whirlpool 8-bit S-box
module whirlpool_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row r holds S(16r) .. S(16r+15), first entry in the most significant byte.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h1823c6e887b8014f36a6d2f5796f9152,
        128'h60bc9b8ea30c7b351de0d7c22e4bfe57,
        128'h157737e59ff04ada58c9290ab1a06b85,
        128'hbd5d10f4cb3e0567e427418ba77d95d8,
        128'hfbee7c66dd17479eca2dbf07ad5a8333,
        128'h6302aa71c81949d9f2e35b889a2632b0,
        128'he90fd580becd3448ff7a905f20681aae,
        128'hb454932264f173124008c3ecdba18d3d,
        128'h9700cf2b7682d61bb5af6a5045f330ef,
        128'h3f55a2ea65ba2fc0de1cfd4d9275068a,
        128'hb2e60e1f62d4a896f9c525598472394c,
        128'h5e78388cd1a5e261b3219c1e43c7fc04,
        128'h51996d0dfadf7e243babce118f4eb7eb,
        128'h3c8194f7b9132cd3e76ec40356447fa9,
        128'h2abbc153dc0b9d6c3174f646ac8914e1,
        128'h163a690970b6d0edcc4298a4285cf886
    };

    assign o_byte = SBOX_TABLE[i_byte];

endmodule

// File: rtl/whirlpool_sub_bytes_seq.sv
// rtl/whirlpool_sub_bytes_seq.sv - sequential Whirlpool SubBytes engine, LANES bytes per cycle
module whirlpool_sub_bytes_seq
    import whirlpool_sub_bytes_seq_pkg::*;
#(
    parameter int STATE_BYTES = WP_STATE_BYTES,
    parameter int LANES       = 8,
    parameter int PIPE        = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*STATE_BYTES-1:0] in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*STATE_BYTES-1:0] out_state,
    output logic                     busy
);

    localparam int BEATS   = STATE_BYTES / LANES;
    localparam int CNT_W   = (wp_clog2(BEATS) < 1) ? 1 : wp_clog2(BEATS);
    localparam int SLICE_W = 8 * LANES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    if ((LANES < 1) || (LANES > STATE_BYTES) || ((STATE_BYTES % LANES) != 0)) begin : g_bad_cfg
        $error("whirlpool_sub_bytes_seq: STATE_BYTES must be a multiple of LANES, LANES in 1..STATE_BYTES");
    end

    wp_state_e            r_state;
    wp_state_e            w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [8*STATE_BYTES-1:0] r_buf;
    logic                 r_pipe_vld;
    logic [CNT_W-1:0]     r_pipe_idx;
    logic [SLICE_W-1:0]   r_pipe_data;
    logic                 r_issue_done;
    logic [SLICE_W-1:0]   w_slice_in;
    logic [SLICE_W-1:0]   w_slice_out;
    logic                 w_last;

    // Select the slice currently being substituted.
    always_comb begin
        w_slice_in = r_buf[SLICE_W*int'(r_cnt) +: SLICE_W];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        whirlpool_sbox u_sbox (
            .i_byte (w_slice_in[8*g +: 8]),
            .o_byte (w_slice_out[8*g +: 8])
        );
    end

    // With the pipe stage the run ends on the writeback of the final slice, not on its issue.
    assign w_last = (PIPE != 0) ? (r_pipe_vld && (r_pipe_idx == LAST)) : (r_cnt == LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Buffer capture, slice writeback, beat counter and optional pipe stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_pipe_vld   <= 1'b0;
            r_pipe_idx   <= '0;
            r_pipe_data  <= '0;
            r_issue_done <= 1'b0;
        end else begin
            r_pipe_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_buf        <= in_state;
                        r_cnt        <= '0;
                        r_issue_done <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (PIPE == 0) begin
                        r_buf[SLICE_W*int'(r_cnt) +: SLICE_W] <= w_slice_out;
                        if (r_cnt != LAST) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        if (!r_issue_done) begin
                            r_pipe_vld  <= 1'b1;
                            r_pipe_idx  <= r_cnt;
                            r_pipe_data <= w_slice_out;
                            if (r_cnt == LAST) begin
                                r_issue_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        // Writeback slot never collides with the slice being read: indices differ by one.
                        if (r_pipe_vld) begin
                            r_buf[SLICE_W*int'(r_pipe_idx) +: SLICE_W] <= r_pipe_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_state = r_buf;

endmodule

// File: tb/tb_whirlpool_sub_bytes_seq.sv
// tb/tb_whirlpool_sub_bytes_seq.sv - self-checking bench over six LANES/PIPE configurations
module tb_whirlpool_sub_bytes_seq;

    localparam int SB   = 64;
    localparam int NCFG = 6;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic clk = 1'b0;
    wire [NCFG-1:0] all_done;

    always #5 clk = ~clk;

    function automatic int cfg_lanes(input int i);
        case (i / 2)
            0:       return 1;
            1:       return 8;
            default: return 64;
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [63:0] t, input int i);
        logic [63:0] v;
        v = t;
        return v[63-4*i -: 4];
    endfunction

    // Whirlpool S-box built from its E, E^-1 and R mini-boxes.
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [63:0] e_tab;
        logic [63:0] r_tab;
        logic [3:0]  ei [16];
        logic [3:0]  u, l, r;
        e_tab = 64'h1B9CD6F3E874A250;
        r_tab = 64'h7CBDE49F638A2510;
        for (int i = 0; i < 16; i++) begin
            ei[nib(e_tab, i)] = 4'(i);
        end
        u = nib(e_tab, int'(x[7:4]));
        l = ei[x[3:0]];
        r = nib(r_tab, int'(u ^ l));
        return {nib(e_tab, int'(u ^ r)), ei[l ^ r]};
    endfunction

    function automatic logic [511:0] ref_state(input logic [511:0] s);
        logic [511:0] o;
        for (int i = 0; i < SB; i++) begin
            o[8*i +: 8] = ref_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic logic [511:0] rnd_state();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            r[32*i +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic check(input int cfg, input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %h want %h", cfg, nm, act, exp);
        end
    endtask

    task automatic check1(input int cfg, input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %b want %b", cfg, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int LN = cfg_lanes(g);
        localparam int PP = g % 2;
        localparam int L  = SB / LN + PP;

        logic         rst_n     = 1'b0;
        logic         in_valid  = 1'b0;
        logic         out_ready = 1'b1;
        logic [511:0] in_state  = '0;
        logic         in_ready;
        logic         out_valid;
        logic         busy;
        logic [511:0] out_state;
        int           cyc = 0;
        bit           b2b = 1'b0;
        bit           fin = 1'b0;

        logic [511:0] q_exp [$];
        int           q_acc [$];
        int           last_rise = -1;
        logic         prev_ov = 1'b0;
        logic         exp_ov;

        assign all_done[g] = fin;

        whirlpool_sub_bytes_seq #(.STATE_BYTES(SB), .LANES(LN), .PIPE(PP)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_state  (in_state),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_state (out_state),
            .busy      (busy)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Compare process: one state in flight, output due BEATS+PIPE edges after its accept edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                q_exp.delete();
                q_acc.delete();
                check1(g, "out_valid in reset", out_valid, 1'b0);
                check1(g, "busy in reset", busy, 1'b0);
                check(g, "out_state in reset", out_state, '0);
                prev_ov = 1'b0;
            end else begin
                check1(g, "in_ready", in_ready, q_exp.size() == 0);
                check1(g, "busy", busy, q_exp.size() != 0);
                exp_ov = 1'b0;
                if (q_exp.size() != 0) exp_ov = (cyc >= q_acc[0] + L);
                check1(g, "out_valid", out_valid, exp_ov);
                if (out_valid && (q_exp.size() != 0)) begin
                    check(g, "out_state", out_state, q_exp[0]);
                    if (!prev_ov) begin
                        if (b2b && (last_rise >= 0)) begin
                            n_tests++;
                            if (cyc - last_rise != L + 2) begin
                                n_fail++;
                                $display("FAIL c%0d b2b interval: got %0d want %0d", g, cyc - last_rise, L + 2);
                            end
                        end
                        last_rise = b2b ? cyc : -1;
                    end
                    if (out_ready) begin
                        void'(q_exp.pop_front());
                        void'(q_acc.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    q_exp.push_back(ref_state(in_state));
                    q_acc.push_back(cyc + 1);
                end
                prev_ov = out_valid;
            end
        end

        task automatic send(input logic [511:0] s, output int acc_edge);
            in_state = s;
            in_valid = 1'b1;
            acc_edge = -1;
            for (int i = 0; (i < 400) && (acc_edge < 0); i++) begin
                @(negedge clk);
                if (in_ready) acc_edge = cyc + 1;
                @(posedge clk);
                #1;
            end
            if (!b2b) in_valid = 1'b0;
            if (acc_edge < 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL c%0d accept timeout: got none want accept", g);
            end
        endtask

        task automatic wait_out(output logic [511:0] got);
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && (n < 400)) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL c%0d output timeout: got none want out_valid", g);
            end
            got = out_state;
            @(posedge clk);
            #1;
        endtask

        logic [511:0] s;
        logic [511:0] got;
        int           acc;
        int           hoff;

        initial begin
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;

            // Known bytes with literal expectations.
            s = '0;
            s[15:8]    = 8'h01;
            s[23:16]   = 8'h06;
            s[511:504] = 8'hFF;
            send(s, acc);
            wait_out(got);
            check(g, "known byte0",  512'(got[7:0]),     512'(8'h18));
            check(g, "known byte1",  512'(got[15:8]),    512'(8'h23));
            check(g, "known byte2",  512'(got[23:16]),   512'(8'h01));
            check(g, "known byte10", 512'(got[87:80]),   512'(8'h18));
            check(g, "known byte63", 512'(got[511:504]), 512'(8'h86));

            // Full table: byte i of state k is 64k+i.
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < SB; i++) s[8*i +: 8] = 8'(64 * k + i);
                send(s, acc);
                wait_out(got);
                if (k == 0) check(g, "table 0x0F", 512'(got[127:120]), 512'(8'h52));
                if (k == 0) check(g, "table 0x10", 512'(got[135:128]), 512'(8'h60));
            end

            // Backpressure: hold DONE for 10 cycles with a second state offered.
            out_ready = 1'b0;
            send(rnd_state(), acc);
            wait_out(got);
            in_state = rnd_state();
            in_valid = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check(g, "bp held state", out_state, got);
            check1(g, "bp in_ready", in_ready, 1'b0);
            out_ready = 1'b1;
            hoff = cyc + 1;
            send(in_state, acc);
            n_tests++;
            if (acc != hoff + 1) begin
                n_fail++;
                $display("FAIL c%0d bp second accept edge: got %0d want %0d", g, acc, hoff + 1);
            end
            wait_out(got);

            // Reset three cycles after accept; the aborted state must never appear.
            send(rnd_state(), acc);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            check1(g, "post-reset in_ready", in_ready, 1'b1);
            check1(g, "post-reset out_valid", out_valid, 1'b0);
            repeat (L + 10) @(posedge clk);
            #1;

            // Back-to-back: in_valid and out_ready held high.
            b2b = 1'b1;
            for (int k = 0; k < 5; k++) send(rnd_state(), acc);
            in_valid = 1'b0;
            for (int i = 0; (i < 400) && busy; i++) @(posedge clk);
            #1;
            check1(g, "b2b drained", busy, 1'b0);
            b2b = 1'b0;
            repeat (2) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        check(-1, "model S(00)", 512'(ref_sbox(8'h00)), 512'(8'h18));
        check(-1, "model S(01)", 512'(ref_sbox(8'h01)), 512'(8'h23));
        check(-1, "model S(06)", 512'(ref_sbox(8'h06)), 512'(8'h01));
        check(-1, "model S(0F)", 512'(ref_sbox(8'h0F)), 512'(8'h52));
        check(-1, "model S(10)", 512'(ref_sbox(8'h10)), 512'(8'h60));
        check(-1, "model S(FF)", 512'(ref_sbox(8'hFF)), 512'(8'h86));
        for (int i = 0; (i < 40000) && !(&all_done); i++) @(posedge clk);
        if (!(&all_done)) begin
            n_tests++;
            n_fail++;
            $display("FAIL global timeout: got done=%b want all ones", all_done);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
